// File: rtl/bf_relax_engine_if.sv
// Request/response handshake and 2R1W working-memory bus for the Bellman-Ford relax engine.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse per transfer.
interface bf_relax_engine_if;
   logic         req_valid;
   logic         req_ready;
   logic [15:0]  req_u;
   logic [15:0]  req_v;
   logic [15:0]  req_w;
   logic         resp_valid;
   logic         resp_updated;
   logic [12:0]  sram_raddr1;
   logic [12:0]  sram_raddr2;
   logic [127:0] sram_rdata1;
   logic [127:0] sram_rdata2;
   logic         sram_we;
   logic [12:0]  sram_waddr;
   logic [127:0] sram_wdata;

   // Engine side: masters the memory bus and answers edge requests.
   modport master (
      input  req_valid, req_u, req_v, req_w, sram_rdata1, sram_rdata2,
      output req_ready, resp_valid, resp_updated,
      output sram_raddr1, sram_raddr2, sram_we, sram_waddr, sram_wdata
   );

   // Client side: issues edge requests and hosts the memory.
   modport slave (
      output req_valid, req_u, req_v, req_w, sram_rdata1, sram_rdata2,
      input  req_ready, resp_valid, resp_updated,
      input  sram_raddr1, sram_raddr2, sram_we, sram_waddr, sram_wdata
   );
endinterface

// File: rtl/bf_relax_engine.sv
// Bellman-Ford edge relaxation engine: reads dist[u] and dist[v] in parallel and writes back
// dist[v] = dist[u] + w when strictly smaller. One request in flight; all outputs registered.
module bf_relax_engine #(
   parameter int READ_WAIT = 1,
   parameter int DIST_W    = 16,
   parameter int CNT_W     = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   bf_relax_engine_if.master  bus,
   input  logic               clear_stats,
   output logic               changed,
   output logic [CNT_W-1:0]   update_count,
   output logic               busy,
   output logic [2:0]         dbgState
);

   localparam int         LANES     = 128 / DIST_W;
   localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      EVAL  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } stateType;

   stateType          state;
   stateType          stateNext;
   logic [15:0]       uQ;
   logic [15:0]       vQ;
   logic [15:0]       wQ;
   logic [2:0]        waitCnt;
   logic [127:0]      word1;
   logic [127:0]      word2;
   logic [DIST_W-1:0] du;
   logic [DIST_W-1:0] dv;
   logic [DIST_W:0]   sum;
   logic              improve;
   logic [127:0]      mergedWord;

   assign dbgState = state;

   // Lane select and candidate; the 17-bit sum keeps a carry-out from ever looking smaller.
   always_comb begin
      du = '0;
      dv = '0;
      for (int i = 0; i < LANES; i++) begin
         if (uQ[2:0] == 3'(i)) du = word1[i*DIST_W +: DIST_W];
         if (vQ[2:0] == 3'(i)) dv = word2[i*DIST_W +: DIST_W];
      end
      sum     = {1'b0, du} + {1'b0, wQ};
      improve = (du != {DIST_W{1'b1}}) && (sum < {1'b0, dv}) && (uQ != vQ);
      mergedWord = word2;
      for (int i = 0; i < LANES; i++) begin
         if (vQ[2:0] == 3'(i)) mergedWord[i*DIST_W +: DIST_W] = sum[DIST_W-1:0];
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.req_valid) stateNext = READ;
         READ:    if (waitCnt == 3'd1) stateNext = EVAL;
         EVAL:    stateNext = improve ? WRITE : DONE;
         WRITE:   stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         bus.req_ready    <= 1'b1;
         bus.resp_valid   <= 1'b0;
         bus.resp_updated <= 1'b0;
         bus.sram_raddr1  <= '0;
         bus.sram_raddr2  <= '0;
         bus.sram_we      <= 1'b0;
         bus.sram_waddr   <= '0;
         bus.sram_wdata   <= '0;
         busy             <= 1'b0;
         changed          <= 1'b0;
         update_count     <= '0;
         uQ               <= '0;
         vQ               <= '0;
         wQ               <= '0;
         waitCnt          <= '0;
         word1            <= '0;
         word2            <= '0;
      end else begin
         state <= stateNext;
         // Flags follow the next state so they are valid in the same cycle the state is.
         bus.req_ready    <= (stateNext == IDLE);
         busy             <= (stateNext != IDLE);
         bus.resp_valid   <= (stateNext == DONE);
         bus.resp_updated <= (stateNext == DONE) && (state == WRITE);
         bus.sram_we      <= (stateNext == WRITE);

         if (state == IDLE && bus.req_valid) begin
            uQ              <= bus.req_u;
            vQ              <= bus.req_v;
            wQ              <= bus.req_w;
            bus.sram_raddr1 <= bus.req_u[15:3];
            bus.sram_raddr2 <= bus.req_v[15:3];
            waitCnt         <= WAIT_INIT;
         end

         if (state == READ) begin
            waitCnt <= waitCnt - 3'd1;
            if (waitCnt == 3'd1) begin
               word1 <= bus.sram_rdata1;
               word2 <= bus.sram_rdata2;
            end
         end

         // Write address/data are left untouched afterwards so they stay stable through DONE.
         if (state == EVAL && improve) begin
            bus.sram_waddr <= vQ[15:3];
            bus.sram_wdata <= mergedWord;
         end

         if (clear_stats) begin
            update_count <= '0;
            changed      <= 1'b0;
         end else if (state == WRITE) begin
            update_count <= update_count + CNT_W'(1);
            changed      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bf_relax_engine.sv
// Self-checking bench for bf_relax_engine: directed corner cases plus random edges against a
// per-node distance model; memory words are rebuilt from the model to predict every write.
module tb_bf_relax_engine;

   localparam int READ_WAIT = 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        clear_stats = 1'b0;
   logic        changed;
   logic        busy;
   logic [31:0] update_count;
   logic [2:0]  dbgState;

   bf_relax_engine_if bus ();

   bf_relax_engine #(.READ_WAIT(READ_WAIT), .DIST_W(16), .CNT_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .bus          (bus),
      .clear_stats  (clear_stats),
      .changed      (changed),
      .update_count (update_count),
      .busy         (busy),
      .dbgState     (dbgState)
   );

   always #5 clock = ~clock;

   // Memory model: combinational read, write on rising edge; backdoor port for preloading.
   logic [127:0] mem [0:8191];
   logic         bdWe = 1'b0;
   logic [12:0]  bdAddr = '0;
   logic [127:0] bdData = '0;

   always @(posedge clock) begin
      if (bdWe) mem[bdAddr] <= bdData;
      if (bus.sram_we) mem[bus.sram_waddr] <= bus.sram_wdata;
   end

   assign bus.sram_rdata1 = mem[bus.sram_raddr1];
   assign bus.sram_rdata2 = mem[bus.sram_raddr2];

   // Reference model: one distance per node id (nodes 0..511, words 0..63).
   logic [15:0]  refDist [0:511];
   logic [140:0] expWrQ[$];
   logic         expUpdQ[$];
   logic [31:0]  expCntQ[$];
   logic         expChgQ[$];
   logic [31:0]  expCount = '0;
   logic         expChanged = 1'b0;
   int checks = 0;
   int errors = 0;
   int writesExpected = 0;
   int writesSeen = 0;
   int respExpected = 0;
   int respSeen = 0;

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] buildWord(input int addr);
      logic [127:0] w;
      for (int i = 0; i < 8; i++) w[i*16 +: 16] = refDist[addr*8 + i];
      return w;
   endfunction

   function automatic logic [15:0] randDist();
      case ($urandom_range(0, 3))
         0:       return 16'hFFFF;
         1:       return 16'($urandom_range(16'hFF00, 16'hFFFE));
         default: return 16'($urandom_range(0, 2000));
      endcase
   endfunction

   task automatic writeWord(input int addr, input logic [127:0] d);
      @(negedge clock);
      bdAddr = 13'(addr);
      bdData = d;
      bdWe   = 1'b1;
      @(negedge clock);
      bdWe   = 1'b0;
   endtask

   task automatic setNode(input int id, input logic [15:0] val);
      refDist[id] = val;
      writeWord(id / 8, buildWord(id / 8));
   endtask

   // Called at a falling edge; returns at the falling edge right after the accepting edge.
   task automatic sendEdge(input int u, input int v, input int w);
      int du, dv, sum, n;
      bit imp;
      bus.req_u     = 16'(u);
      bus.req_v     = 16'(v);
      bus.req_w     = 16'(w);
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) begin
         checkVal("accept_timeout", 0, 1);
         bus.req_valid = 1'b0;
         return;
      end
      du  = int'(refDist[u]);
      dv  = int'(refDist[v]);
      sum = du + w;
      imp = (du != 65535) && (sum < dv) && (u != v);
      if (imp) begin
         refDist[v] = 16'(sum);
         expWrQ.push_back({13'(v / 8), buildWord(v / 8)});
         expCount++;
         expChanged = 1'b1;
         writesExpected++;
      end
      expUpdQ.push_back(imp);
      expCntQ.push_back(expCount);
      expChgQ.push_back(expChanged);
      respExpected++;
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while ((busy || expUpdQ.size() != 0) && n < 100);
      if (n >= 100) checkVal("idle_timeout", 0, 1);
   endtask

   // Falling edges from the post-accept edge until resp_valid shows.
   task automatic checkLatency(input string tag, input int expEdges);
      int k = 0;
      checkVal("ready_low_after_accept", bus.req_ready, 0);
      while (!bus.resp_valid && k < 20) begin
         @(negedge clock);
         k++;
      end
      checkVal(tag, k, expEdges);
   endtask

   task automatic waitWritePhase(input string tag);
      int n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!bus.sram_we && n < 20);
      if (!bus.sram_we) checkVal(tag, 0, 1);
   endtask

   // Scoreboard: every write and every response is matched against the model queues.
   always @(negedge clock) begin
      if (bus.sram_we) begin
         writesSeen++;
         if (expWrQ.size() == 0) checkVal("unexpected_write", 1, 0);
         else begin
            logic [140:0] e;
            e = expWrQ.pop_front();
            checkVal("sram_waddr", bus.sram_waddr, e[140:128]);
            checkVal("sram_wdata", bus.sram_wdata, e[127:0]);
         end
      end
      if (bus.resp_valid) begin
         respSeen++;
         if (expUpdQ.size() == 0) checkVal("unexpected_resp", 1, 0);
         else begin
            checkVal("resp_updated", bus.resp_updated, expUpdQ.pop_front());
            checkVal("update_count", update_count, expCntQ.pop_front());
            checkVal("changed", changed, expChgQ.pop_front());
         end
      end
   end

   initial begin
      int u, v, w;
      bus.req_valid = 1'b0;
      bus.req_u     = '0;
      bus.req_v     = '0;
      bus.req_w     = '0;
      for (int i = 0; i < 512; i++) refDist[i] = randDist();

      #1 reset_n = 1'b0;
      #2;
      checkVal("rst_req_ready", bus.req_ready, 1);
      checkVal("rst_resp_valid", bus.resp_valid, 0);
      checkVal("rst_sram_we", bus.sram_we, 0);
      checkVal("rst_raddrs", {bus.sram_raddr1, bus.sram_raddr2, bus.sram_waddr}, 0);
      checkVal("rst_wdata", bus.sram_wdata, 0);
      checkVal("rst_stats", {update_count, changed, busy}, 0);

      for (int a = 0; a < 64; a++) writeWord(a, buildWord(a));
      @(negedge clock);
      reset_n = 1'b1;

      // Basic improve, then no improve from the same setup.
      setNode(2, 16'd10);
      setNode(13, 16'd100);
      sendEdge(2, 13, 5);
      checkLatency("latency_write", READ_WAIT + 2);
      waitIdle();
      setNode(13, 16'd100);
      sendEdge(2, 13, 95);
      checkLatency("latency_nowrite", READ_WAIT + 1);
      waitIdle();

      // Infinity, 17-bit overflow, equal sum, and the largest finite improvement.
      setNode(20, 16'hFFFF);
      setNode(30, 16'd50);
      sendEdge(20, 30, 0);
      setNode(21, 16'hFFF0);
      setNode(31, 16'hFFFF);
      sendEdge(21, 31, 16'h20);
      setNode(40, 16'd10);
      setNode(41, 16'd15);
      sendEdge(40, 41, 5);
      setNode(50, 16'hFFF0);
      setNode(60, 16'hFFFF);
      sendEdge(50, 60, 16'hE);
      waitIdle();

      // Same-word source and destination, then a self edge.
      setNode(8, 16'd3);
      setNode(15, 16'd50);
      sendEdge(8, 15, 4);
      sendEdge(9, 9, 0);
      waitIdle();

      // Back-to-back with req_valid held between requests.
      setNode(64, 16'd1);
      setNode(65, 16'd500);
      setNode(72, 16'd700);
      sendEdge(64, 65, 2);
      sendEdge(65, 72, 3);
      sendEdge(72, 64, 1);
      waitIdle();

      // clear_stats landing in the write cycle beats the increment.
      setNode(80, 16'd7);
      setNode(90, 16'd900);
      sendEdge(80, 90, 1);
      expCount = '0;
      expChanged = 1'b0;
      expCntQ[expCntQ.size()-1] = '0;
      expChgQ[expChgQ.size()-1] = 1'b0;
      waitWritePhase("clear_we_timeout");
      clear_stats = 1'b1;
      @(posedge clock);
      #1 clear_stats = 1'b0;
      waitIdle();

      // Reset during the write cycle: no write, no response, stats back to zero.
      sendEdge(64, 65, 0);
      waitIdle();
      setNode(100, 16'd5);
      setNode(200, 16'd1000);
      bus.req_u = 16'd100;
      bus.req_v = 16'd200;
      bus.req_w = 16'd1;
      bus.req_valid = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      waitWritePhase("rstmid_we_timeout");
      reset_n = 1'b0;
      #1;
      checkVal("rstmid_we_drop", bus.sram_we, 0);
      checkVal("rstmid_resp", bus.resp_valid, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      checkVal("rstmid_ready", bus.req_ready, 1);
      checkVal("rstmid_busy", busy, 0);
      checkVal("rstmid_count", update_count, 0);
      checkVal("rstmid_changed", changed, 0);
      expCount = '0;
      expChanged = 1'b0;

      // Random edges, clustered in a few words so same-word cases occur often.
      for (int n = 0; n < 200; n++) begin
         u = $urandom_range(0, 511);
         case ($urandom_range(0, 7))
            0:       v = u;
            1, 2:    v = (u & ~7) | $urandom_range(0, 7);
            default: v = $urandom_range(0, 511);
         endcase
         case ($urandom_range(0, 3))
            0:       w = $urandom_range(0, 40);
            1:       w = $urandom_range(16'hF000, 16'hFFFF);
            default: w = $urandom_range(0, 3000);
         endcase
         sendEdge(u, v, w);
         if ($urandom_range(0, 2) == 0) begin
            waitIdle();
            if ($urandom_range(0, 3) == 0) setNode($urandom_range(0, 511), randDist());
         end
      end
      waitIdle();

      checkVal("writes_total", writesSeen, writesExpected);
      checkVal("resps_total", respSeen, respExpected);
      checkVal("write_queue_empty", expWrQ.size(), 0);
      for (int a = 0; a < 64; a++) checkVal($sformatf("mem_word_%0d", a), mem[a], buildWord(a));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
